// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo encodings: instruction fields, functs, tags
// and the issue bundle used by issue, reservation stations and CDB.
package tomasulo_pkg;

  localparam int INSTR_W = 16;
  localparam int TAG_W   = 3;
  localparam int REG_W   = 3;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 13;
  localparam int RD_HI  = 12;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 7;
  localparam int RT_HI  = 6;
  localparam int RT_LO  = 4;
  localparam int FN_HI  = 3;
  localparam int FN_LO  = 0;

  localparam logic [2:0] OPC_ALU = 3'b000;
  localparam logic [3:0] FN_ADD  = 4'b0000;
  localparam logic [3:0] FN_SUB  = 4'b0001;
  localparam logic [3:0] FN_MUL  = 4'b0100;

  localparam logic [TAG_W-1:0] TAG_READY = 3'd0;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2
  } op_e;

  typedef struct packed {
    logic             legal;
    logic             unit;
    op_e              op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } dec_t;

  typedef struct packed {
    logic             unit;
    op_e              op;
    logic [TAG_W-1:0] tag;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
  } issue_t;

  function automatic dec_t decode(input logic [INSTR_W-1:0] w);
    dec_t       d;
    logic       ok;
    logic [3:0] fn;
    ok      = (w[OPC_HI:OPC_LO] == OPC_ALU);
    fn      = w[FN_HI:FN_LO];
    d.rd    = w[RD_HI:RD_LO];
    d.rs    = w[RS_HI:RS_LO];
    d.rt    = w[RT_HI:RT_LO];
    d.legal = 1'b0;
    d.unit  = 1'b0;
    d.op    = OP_ADD;
    unique case (1'b1)
      ok && fn == FN_ADD: begin
        d.legal = 1'b1;
      end
      ok && fn == FN_SUB: begin
        d.legal = 1'b1;
        d.op    = OP_SUB;
      end
      ok && fn == FN_MUL: begin
        d.legal = 1'b1;
        d.unit  = 1'b1;
        d.op    = OP_MUL;
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/reg_status.sv
// Register tag table: which station will produce each register.
// One issue write port, CDB clear, two combinational reads.
module reg_status
  import tomasulo_pkg::*;
#(
  parameter int NREG = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [REG_W-1:0] waddr,
  input  logic [TAG_W-1:0] wtag,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic [REG_W-1:0] raddr_a,
  input  logic [REG_W-1:0] raddr_b,
  output logic [TAG_W-1:0] rtag_a,
  output logic [TAG_W-1:0] rtag_b
);

  logic [TAG_W-1:0] tag_q [NREG];
  logic [TAG_W-1:0] tag_d [NREG];

  // issue write is applied last so it beats a same-cycle clear
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      tag_d[r] = tag_q[r];
      if (clr_en && tag_q[r] == clr_tag) tag_d[r] = TAG_READY;
      if (we && waddr == REG_W'(r)) tag_d[r] = wtag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) tag_q[r] <= TAG_READY;
    end else begin
      for (int r = 0; r < NREG; r++) tag_q[r] <= tag_d[r];
    end
  end

  assign rtag_a = tag_q[raddr_a];
  assign rtag_b = tag_q[raddr_b];

endmodule

// File: rtl/issue_ctrl.sv
// Tomasulo issue stage: one-entry holding register, station
// allocation, register renaming and registered issue bundle.
module issue_ctrl
  import tomasulo_pkg::*;
#(
  parameter int ADD_RS = 3,
  parameter int MUL_RS = 2,
  parameter int NREG   = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               instrValid,
  input  logic [INSTR_W-1:0] instrIn,
  output logic               disponivel,
  input  logic               cdbValid,
  input  logic [TAG_W-1:0]   cdbTag,
  output logic               issueValid,
  output logic               issueUnit,
  output logic [1:0]         issueOp,
  output logic [TAG_W-1:0]   issueTag,
  output logic [REG_W-1:0]   issueRd,
  output logic [REG_W-1:0]   issueRs,
  output logic [REG_W-1:0]   issueRt,
  output logic [TAG_W-1:0]   issueQj,
  output logic [TAG_W-1:0]   issueQk,
  output logic               illegalOp
);

  localparam int NRS = ADD_RS + MUL_RS;

  typedef enum logic {EMPTY, HELD} state_e;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [NRS-1:0]     busy_q, busy_d;
  issue_t             iss_q, iss_d;
  logic               valid_q, valid_d;
  logic               ill_q, ill_d;

  dec_t             dec;
  logic             found;
  logic             issue_go;
  logic             drop;
  logic             accept;
  logic             cdb_hit;
  logic [TAG_W-1:0] alloc_tag;
  logic [TAG_W-1:0] qj_raw, qk_raw;
  logic [TAG_W-1:0] qj, qk;

  assign dec     = decode(instr_q);
  assign cdb_hit = cdbValid && cdbTag != TAG_READY
                && int'(cdbTag) <= NRS;

  // stations 0..ADD_RS-1 are adders, the rest multipliers
  always_comb begin
    found     = 1'b0;
    alloc_tag = TAG_READY;
    for (int i = 0; i < NRS; i++) begin
      if (!found && !busy_q[i]
          && ((i >= ADD_RS) == dec.unit)) begin
        found     = 1'b1;
        alloc_tag = TAG_W'(i + 1);
      end
    end
  end

  assign issue_go   = state_q == HELD && dec.legal && found;
  assign drop       = state_q == HELD && !dec.legal;
  assign disponivel = state_q == EMPTY || issue_go;
  assign accept     = instrValid && disponivel;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    unique case (state_q)
      EMPTY: if (accept) state_d = HELD;
      HELD: begin
        if (issue_go || drop) state_d = accept ? HELD : EMPTY;
      end
    endcase
    if (accept) instr_d = instrIn;
  end

  // a station freed by the CDB is seen free only next cycle
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NRS; i++) begin
      if (cdb_hit && cdbTag == TAG_W'(i + 1)) busy_d[i] = 1'b0;
      if (issue_go && alloc_tag == TAG_W'(i + 1)) busy_d[i] = 1'b1;
    end
  end

  reg_status #(
    .NREG(NREG)
  ) u_reg_status (
    .clk    (Clock),
    .rst_n  (Reset),
    .we     (issue_go),
    .waddr  (dec.rd),
    .wtag   (alloc_tag),
    .clr_en (cdb_hit),
    .clr_tag(cdbTag),
    .raddr_a(dec.rs),
    .raddr_b(dec.rt),
    .rtag_a (qj_raw),
    .rtag_b (qk_raw)
  );

  assign qj = (cdb_hit && qj_raw == cdbTag) ? TAG_READY : qj_raw;
  assign qk = (cdb_hit && qk_raw == cdbTag) ? TAG_READY : qk_raw;

  always_comb begin
    iss_d   = iss_q;
    valid_d = issue_go;
    ill_d   = drop;
    if (issue_go) begin
      iss_d.unit = dec.unit;
      iss_d.op   = dec.op;
      iss_d.tag  = alloc_tag;
      iss_d.rd   = dec.rd;
      iss_d.rs   = dec.rs;
      iss_d.rt   = dec.rt;
      iss_d.qj   = qj;
      iss_d.qk   = qk;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= EMPTY;
      instr_q <= '0;
      busy_q  <= '0;
      iss_q   <= '0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      busy_q  <= busy_d;
      iss_q   <= iss_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
    end
  end

  assign issueValid = valid_q;
  assign illegalOp  = ill_q;
  assign issueUnit  = iss_q.unit;
  assign issueOp    = iss_q.op;
  assign issueTag   = iss_q.tag;
  assign issueRd    = iss_q.rd;
  assign issueRs    = iss_q.rs;
  assign issueRt    = iss_q.rt;
  assign issueQj    = iss_q.qj;
  assign issueQk    = iss_q.qk;

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: behavioural model predicts
// each issue/drop; a negedge monitor pops and compares.
module tb_issue_ctrl;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        instrValid = 1'b0;
  logic [15:0] instrIn = '0;
  logic        disponivel;
  logic        cdbValid = 1'b0;
  logic [2:0]  cdbTag = '0;
  logic        issueValid;
  logic        issueUnit;
  logic [1:0]  issueOp;
  logic [2:0]  issueTag;
  logic [2:0]  issueRd, issueRs, issueRt;
  logic [2:0]  issueQj, issueQk;
  logic        illegalOp;

  always #5 Clock = ~Clock;

  issue_ctrl dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .instrValid(instrValid),
    .instrIn   (instrIn),
    .disponivel(disponivel),
    .cdbValid  (cdbValid),
    .cdbTag    (cdbTag),
    .issueValid(issueValid),
    .issueUnit (issueUnit),
    .issueOp   (issueOp),
    .issueTag  (issueTag),
    .issueRd   (issueRd),
    .issueRs   (issueRs),
    .issueRt   (issueRt),
    .issueQj   (issueQj),
    .issueQk   (issueQk),
    .illegalOp (illegalOp)
  );

  typedef struct packed {
    int       cyc;
    logic     ill;
    logic     unit;
    logic [1:0] op;
    logic [2:0] tag;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] qj;
    logic [2:0] qk;
  } rec_t;

  rec_t     sbq[$];
  int       n_tests = 0;
  int       n_fail  = 0;
  int       cyc     = 0;

  // reference state: held instruction, busy per tag, rename table
  bit        m_held;
  bit [15:0] m_ins;
  bit [7:0]  m_busy;
  bit [2:0]  m_tab[8];

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit [15:0] enc(input int rd, input int rs,
                                    input int rt, input int fn);
    bit [15:0] w;
    w = {3'b000, 3'(rd), 3'(rs), 3'(rt), 4'(fn)};
    return w;
  endfunction

  function automatic int free_tag(input bit mul);
    int lo = mul ? 4 : 1;
    int hi = mul ? 5 : 3;
    for (int t = lo; t <= hi; t++) if (!m_busy[t]) return t;
    return 0;
  endfunction

  task automatic model_reset();
    m_held = 0;
    m_ins  = '0;
    m_busy = '0;
    for (int r = 0; r < 8; r++) m_tab[r] = '0;
    sbq.delete();
  endtask

  // runs at the negedge before the edge it predicts
  task automatic model_step(output bit acc);
    bit [15:0] w;
    bit        legal, mul, disp, cv, wr;
    int        ft;
    rec_t      r;
    bit [2:0]  rd, rs, rt, wt;
    w     = m_ins;
    mul   = (w[3:0] == 4'd4);
    legal = (w[15:13] == 3'd0)
         && (w[3:0] == 4'd0 || w[3:0] == 4'd1 || mul);
    ft    = (m_held && legal) ? free_tag(mul) : 0;
    disp  = !m_held || ft != 0;
    check("disponivel", 32'(disponivel), 32'(disp));
    cv = cdbValid && cdbTag >= 3'd1 && cdbTag <= 3'd5;
    rd = w[12:10];
    rs = w[9:7];
    rt = w[6:4];
    wr = 0;
    wt = '0;
    r  = '0;
    r.cyc = cyc;
    if (m_held) begin
      if (!legal) begin
        r.ill = 1;
        sbq.push_back(r);
        m_held = 0;
      end else if (ft != 0) begin
        r.unit = mul;
        r.op   = mul ? 2'd2 : (w[3:0] == 4'd1 ? 2'd1 : 2'd0);
        r.tag  = 3'(ft);
        r.rd   = rd;
        r.rs   = rs;
        r.rt   = rt;
        r.qj   = (cv && m_tab[rs] == cdbTag) ? 3'd0 : m_tab[rs];
        r.qk   = (cv && m_tab[rt] == cdbTag) ? 3'd0 : m_tab[rt];
        sbq.push_back(r);
        m_held = 0;
        wr = 1;
        wt = 3'(ft);
      end
    end
    if (cv) begin
      m_busy[cdbTag] = 0;
      for (int i = 0; i < 8; i++)
        if (m_tab[i] == cdbTag) m_tab[i] = '0;
    end
    if (wr) begin
      m_busy[wt] = 1;
      m_tab[rd]  = wt;
    end
    acc = instrValid && disp;
    if (acc) begin
      m_held = 1;
      m_ins  = instrIn;
    end
  endtask

  always @(negedge Clock) begin
    rec_t r;
    if (Reset) begin
      if (issueValid || illegalOp) begin
        if (sbq.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got v=%0b ill=%0b expected none",
                   issueValid, illegalOp);
        end else begin
          r = sbq.pop_front();
          check("latency", 32'(cyc - r.cyc), 32'd1);
          check("illegalOp", 32'(illegalOp), 32'(r.ill));
          check("issueValid", 32'(issueValid), 32'(!r.ill));
          if (!r.ill)
            check("issue_fields",
                  32'({issueUnit, issueOp, issueTag, issueRd,
                       issueRs, issueRt, issueQj, issueQk}),
                  32'({r.unit, r.op, r.tag, r.rd,
                       r.rs, r.rt, r.qj, r.qk}));
        end
      end else if (sbq.size() != 0 && sbq[0].cyc < cyc) begin
        r = sbq.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missing_output: got none expected tag %0h ill %0b",
                 r.tag, r.ill);
      end
    end
  end

  task automatic cyc_step(input bit iv, input bit [15:0] ins,
                          input bit cv, input bit [2:0] ct,
                          output bit acc);
    instrValid = iv;
    instrIn    = ins;
    cdbValid   = cv;
    cdbTag     = ct;
    @(negedge Clock);
    model_step(acc);
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) cyc_step(0, '0, 0, '0, acc);
  endtask

  task automatic cdb(input int t);
    bit acc;
    cyc_step(0, '0, 1, 3'(t), acc);
  endtask

  task automatic send(input bit [15:0] ins);
    bit acc;
    int n = 0;
    do begin
      cyc_step(1, ins, 0, '0, acc);
      n++;
    end while (!acc && n < 40);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept of %h", ins);
    end
  endtask

  task automatic do_reset();
    Reset      = 1'b0;
    instrValid = 1'b0;
    cdbValid   = 1'b0;
    #2;
    check("rst_disponivel", 32'(disponivel), 32'd1);
    check("rst_issueValid", 32'(issueValid), 32'd0);
    check("rst_illegalOp", 32'(illegalOp), 32'd0);
    model_reset();
    @(posedge Clock);
    #1;
    Reset = 1'b1;
  endtask

  task automatic free_all();
    for (int t = 1; t <= 5; t++) if (m_busy[t]) cdb(t);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit        acc;
    bit        iv, cv;
    bit [2:0]  ct;
    bit [3:0]  fn;
    bit [2:0]  opc;
    bit [15:0] w;
    int        p, k;
    int        bl[$];

    model_reset();
    @(posedge Clock);
    #1;
    do_reset();

    // dependent issue: ADD R3,R1,R2 then SUB R5,R3,R1
    send(16'b0000110010100000);
    send(enc(5, 3, 1, 1));
    idle(2);

    // bypass: SUB R5,R3,R1 issues while the CDB carries tag 1
    cyc_step(1, enc(5, 3, 1, 1), 0, '0, acc);
    cdb(1);
    idle(1);
    // same-cycle rd write beats clear, then read the new tag
    cyc_step(1, enc(5, 5, 0, 0), 0, '0, acc);
    cdb(3);
    send(enc(6, 5, 5, 1));
    idle(2);
    free_all();

    // multiplier stall, freed by tag 4
    send(enc(1, 2, 3, 4));
    send(enc(2, 1, 1, 4));
    send(enc(4, 2, 1, 4));
    idle(3);
    cdb(4);
    idle(3);

    // illegal functs and opcode, then a legal one
    send(16'h0002);
    send(16'h2000);
    send(enc(7, 7, 7, 0));
    send(enc(7, 7, 7, 0));
    idle(2);

    // ignored broadcasts
    cdb(0);
    cdb(6);
    cdb(7);
    send(enc(0, 7, 7, 1));
    idle(2);

    // reset while stalled on a full multiplier pool
    send(enc(3, 3, 3, 4));
    idle(3);
    do_reset();
    idle(4);

    for (int n = 0; n < 700; n++) begin
      iv  = $urandom_range(0, 99) < 70;
      p   = $urandom_range(0, 9);
      fn  = p < 4 ? 4'd0 : p < 6 ? 4'd1 : p < 9 ? 4'd4
                                 : 4'($urandom_range(0, 15));
      opc = $urandom_range(0, 19) == 0 ? 3'($urandom_range(1, 7)) : 3'd0;
      w   = {opc, 3'($urandom), 3'($urandom), 3'($urandom), fn};
      bl.delete();
      for (int t = 1; t <= 5; t++) if (m_busy[t]) bl.push_back(t);
      p  = $urandom_range(0, 9);
      cv = 0;
      ct = '0;
      if (p < 5 && bl.size() != 0) begin
        cv = 1;
        ct = 3'(bl[$urandom_range(0, bl.size() - 1)]);
      end else if (p == 5) begin
        cv = 1;
        k  = $urandom_range(0, 2);
        ct = k == 0 ? 3'd0 : k == 1 ? 3'd6 : 3'd7;
      end
      cyc_step(iv, w, cv, ct, acc);
    end

    k = 0;
    while ((m_held || m_busy != 0 || sbq.size() != 0) && k < 60) begin
      if (m_busy != 0) free_all();
      else idle(1);
      k++;
    end
    idle(3);
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
